// File: rtl/rf_defs.sv
// Shared register-file dimensions, used by the register file, the control
// unit's RegDst mux and the testbench.
package rf_defs;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NREG     = 32;
  localparam int RF_ZERO_IDX = 0;

endpackage : rf_defs

// File: rtl/rf_read_port.sv
// One combinational read port of the register file: index 0 always reads zero.
// With RF_BYPASS_EN defined, a same-cycle write to the read index is forwarded.
module rf_read_port
  import rf_defs::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
`ifdef RF_BYPASS_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic is_zero;

  assign is_zero = (addr == ADDR_W'(RF_ZERO_IDX));

  // NOTE: rdata gets a value on every path first, so no latch is inferred.
  always_comb begin
    rdata = stored;
`ifdef RF_BYPASS_EN
    if (wr_en && (wr_addr == addr)) rdata = wr_data;
`endif
    if (is_zero) rdata = '0;
  end

endmodule : rf_read_port

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two combinational read ports and one write port;
// register 0 is hardwired to zero. Define RF_BYPASS_EN for write-through reads.
module regfile_2r1w
  import rf_defs::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREG   = RF_NREG
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              RFWr,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_armed;
  logic              wr_en;

  // Low through the edge at which rstn is released, so a write presented on
  // that edge is dropped; the first accepted write is on the following edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wr_armed <= 1'b0;
    else       wr_armed <= 1'b1;
  end

  assign wr_en = wr_armed && RFWr && (A3 != ADDR_W'(RF_ZERO_IDX));

  // NOTE: the whole array is async-reset on purpose: every register must hold
  // a defined zero after reset, which rules out a reset-less RAM macro.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[A3] <= WD;
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .addr    (A1),
    .stored  (regs[A1]),
`ifdef RF_BYPASS_EN
    .wr_en   (wr_en),
    .wr_addr (A3),
    .wr_data (WD),
`endif
    .rdata   (RD1)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .addr    (A2),
    .stored  (regs[A2]),
`ifdef RF_BYPASS_EN
    .wr_en   (wr_en),
    .wr_addr (A3),
    .wr_data (WD),
`endif
    .rdata   (RD2)
  );

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed reset/write/hazard cases plus
// random traffic, checked through a scoreboard against an array-based model.
module tb_regfile_2r1w;
  import rf_defs::*;

  logic                 clk;
  logic                 rstn;
  logic                 RFWr;
  logic [RF_ADDR_W-1:0] A1, A2, A3;
  logic [RF_DATA_W-1:0] WD;
  logic [RF_DATA_W-1:0] RD1, RD2;

  regfile_2r1w dut (
    .clk  (clk),
    .rstn (rstn),
    .RFWr (RFWr),
    .A1   (A1),
    .A2   (A2),
    .A3   (A3),
    .WD   (WD),
    .RD1  (RD1),
    .RD2  (RD2)
  );

  typedef struct {
    logic [RF_DATA_W-1:0] rd1;
    logic [RF_DATA_W-1:0] rd2;
    string                name;
  } exp_t;

  exp_t sb[$];

  logic [RF_DATA_W-1:0] model [RF_NREG];
  bit                   model_live;   // writes are being accepted
  logic                 rst_req;      // stimulus request: hold reset
  int                   n_checks;
  int                   n_fail;

  // Reset is asserted 2 time units after a rising edge (mid-cycle) and released
  // in the same time step as, and just before, a rising edge.
  initial begin
    clk  = 1'b0;
    rstn = 1'b0;
    forever begin
      #5;
      if (!rst_req) rstn = 1'b1;
      clk = 1'b1;
      #2;
      if (rst_req) rstn = 1'b0;
      #3;
      clk = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [RF_DATA_W-1:0] act,
                       input logic [RF_DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [RF_DATA_W-1:0] ref_read(
      input logic [RF_ADDR_W-1:0] a, input logic we,
      input logic [RF_ADDR_W-1:0] wa, input logic [RF_DATA_W-1:0] wd);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (model_live && we && (wa != 0) && (wa == a)) return wd;
`endif
    return model[a];
  endfunction

  // Drive one cycle's inputs (at posedge+1) and queue the expected read data.
  task automatic apply(input logic we, input logic [RF_ADDR_W-1:0] a1,
                       input logic [RF_ADDR_W-1:0] a2, input logic [RF_ADDR_W-1:0] a3,
                       input logic [RF_DATA_W-1:0] wd, input string name);
    exp_t e;
    if (rst_req) begin
      for (int i = 0; i < RF_NREG; i++) model[i] = '0;
      model_live = 1'b0;
    end
    RFWr = we; A1 = a1; A2 = a2; A3 = a3; WD = wd;
    e.rd1  = ref_read(a1, we, a3, wd);
    e.rd2  = ref_read(a2, we, a3, wd);
    e.name = name;
    sb.push_back(e);
  endtask

  // Advance past the next rising edge and apply the write rule to the model.
  task automatic step();
    @(posedge clk);
    if (model_live && rstn && RFWr && (A3 != 0)) model[A3] = WD;
    model_live = rstn;
    #1;
  endtask

  task automatic cyc(input logic we, input logic [RF_ADDR_W-1:0] a1,
                     input logic [RF_ADDR_W-1:0] a2, input logic [RF_ADDR_W-1:0] a3,
                     input logic [RF_DATA_W-1:0] wd, input string name);
    apply(we, a1, a2, a3, wd, name);
    step();
  endtask

  // Monitor: read ports are combinational, so sample once per cycle mid-way.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".rd1"}, RD1, e.rd1);
      check({e.name, ".rd2"}, RD2, e.rd2);
    end
  end

  initial begin
    logic [RF_ADDR_W-1:0] ra1, ra2, ra3;
    n_checks   = 0;
    n_fail     = 0;
    rst_req    = 1'b1;
    model_live = 1'b0;
    for (int i = 0; i < RF_NREG; i++) model[i] = '0;
    RFWr = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0;

    repeat (2) @(posedge clk);
    #1;
    cyc(1'b0, 5'd0, 5'd31, 5'd0, 32'h0, "reset_state");
    rst_req = 1'b0;
    cyc(1'b0, 5'd1, 5'd2, 5'd0, 32'h0, "release");

    cyc(1'b1, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, "wr5");
    cyc(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, "rd5");
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, "wr_zero");
    cyc(1'b0, 5'd0, 5'd5, 5'd0, 32'h0, "rd_zero");
    cyc(1'b1, 5'd1, 5'd2, 5'd7, 32'h1, "wr7_init");
    cyc(1'b1, 5'd7, 5'd7, 5'd7, 32'h2, "hazard7");
    cyc(1'b0, 5'd7, 5'd7, 5'd0, 32'h0, "rd7_after");
    cyc(1'b1, 5'd0, 5'd9, 5'd0, 32'h5, "zero_no_bypass");
    cyc(1'b0, 5'd9, 5'd9, 5'd9, 32'h1234, "we_low");
    cyc(1'b0, 5'd9, 5'd5, 5'd0, 32'h0, "rd9");

    // Preload every register, then reset mid-cycle over a pending write.
    for (int i = 1; i < RF_NREG; i++)
      cyc(1'b1, RF_ADDR_W'(i - 1), 5'd5, RF_ADDR_W'(i), $urandom, "preload");
    rst_req = 1'b1;
    cyc(1'b1, 5'd12, 5'd13, 5'd12, $urandom, "rst_pending_wr");
    for (int i = 0; i < RF_NREG; i++)
      cyc(1'b1, RF_ADDR_W'(i), RF_ADDR_W'(31 - i), RF_ADDR_W'($urandom_range(31)),
          $urandom, "rst_sweep");

    // Release coincident with a write edge: that write is dropped.
    rst_req = 1'b0;
    cyc(1'b1, 5'd3, 5'd3, 5'd3, 32'hAA, "rel_race");
    cyc(1'b1, 5'd3, 5'd12, 5'd3, 32'hAA, "rel_retry");
    cyc(1'b0, 5'd3, 5'd3, 5'd0, 32'h0, "rd3");

    for (int n = 0; n < 400; n++) begin
      ra3 = RF_ADDR_W'($urandom_range(31));
      ra1 = ($urandom_range(3) == 0) ? ra3 : RF_ADDR_W'($urandom_range(31));
      ra2 = ($urandom_range(3) == 0) ? ra3 :
            ($urandom_range(7) == 0) ? ra1 : RF_ADDR_W'($urandom_range(31));
      cyc(($urandom_range(2) != 0), ra1, ra2, ra3, $urandom, "random");
    end

    for (int k = 0; k < 4 && sb.size() != 0; k++) @(negedge clk);
    #1;
    check("scoreboard_drain", RF_DATA_W'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_2r1w
